// File: rtl/disp_scan_mux.sv
// Purpose : time-multiplexed N-digit common-anode display driver with double-buffered frames,
//           per-digit enable, anti-ghost blanking and 4-bit PWM brightness.
// Latency : Hex/p/LE/AN are registered, 1 clk behind scan_idx; frames swap only at frame end.
// Backpr. : none; load is always accepted into the shadow buffer (last load in a frame wins).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   Hexs, Point, Les    per-digit nibble / decimal point / latch-enable, captured on load
//   Dig_en              per-digit enable, captured on load (0 keeps that anode off)
//   bright              PWM duty: 0 off, 1..14 = bright/16, 15 = full on (not buffered)
//   load                capture Hexs/Point/Les/Dig_en into the shadow buffer
//   Hex, p, LE          data of the digit being scanned (registered)
//   AN                  active-low anodes, at most one low (registered)
//   scan_idx            digit index currently being scanned
//   frame_done          1-cycle pulse after the active buffer has been refreshed
module disp_scan_mux #(
  parameter  int N_DIGITS  = 8,
  parameter  int PRESCALE  = 100000,
  parameter  int BLANK_CYC = 16,
  localparam int SW        = $clog2(N_DIGITS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] Hexs,
  input  logic [N_DIGITS-1:0]   Point,
  input  logic [N_DIGITS-1:0]   Les,
  input  logic [N_DIGITS-1:0]   Dig_en,
  input  logic [3:0]            bright,
  input  logic                  load,
  output logic [3:0]            Hex,
  output logic                  p,
  output logic                  LE,
  output logic [N_DIGITS-1:0]   AN,
  output logic [SW-1:0]         scan_idx,
  output logic                  frame_done
);

  localparam int CW = $clog2(PRESCALE);

  // Slot phase is decoded from slot_cnt; there is no separate state register.
  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_t;

  // Scan counters
  logic [CW-1:0]         r_slot_cnt;
  logic [SW-1:0]         r_scan_idx;
  logic [3:0]            r_pwm_cnt;

  // Shadow buffer (written by load) and active buffer (displayed)
  logic [4*N_DIGITS-1:0] r_sh_hex;
  logic [N_DIGITS-1:0]   r_sh_pt;
  logic [N_DIGITS-1:0]   r_sh_le;
  logic [N_DIGITS-1:0]   r_sh_en;
  logic [4*N_DIGITS-1:0] r_ac_hex;
  logic [N_DIGITS-1:0]   r_ac_pt;
  logic [N_DIGITS-1:0]   r_ac_le;
  logic [N_DIGITS-1:0]   r_ac_en;

  // Output registers
  logic [3:0]            r_hex;
  logic                  r_p;
  logic                  r_le;
  logic [N_DIGITS-1:0]   r_an;
  logic                  r_frame_done;

  // Combinational decode
  logic                  w_slot_wrap;
  logic                  w_last_dig;
  logic                  w_frame_end;
  phase_t                w_phase;
  logic                  w_pwm_on;
  logic [CW-1:0]         w_slot_next;
  logic [SW-1:0]         w_idx_next;
  logic [N_DIGITS-1:0]   w_an_next;
  logic [3:0]            w_hex_sel;

  always_comb begin
    w_slot_wrap = (r_slot_cnt == CW'(PRESCALE - 1));
    w_last_dig  = (r_scan_idx == SW'(N_DIGITS - 1));
    w_frame_end = w_slot_wrap && w_last_dig;
    w_phase     = (r_slot_cnt < CW'(BLANK_CYC)) ? PH_BLANK : PH_DRIVE;
    // 15 is full-on rather than 15/16 so the top setting has no flicker at all.
    w_pwm_on    = (bright == 4'hF) || (r_pwm_cnt < bright);

    w_slot_next = w_slot_wrap ? '0 : r_slot_cnt + CW'(1);
    w_idx_next  = r_scan_idx;
    if (w_slot_wrap) begin
      w_idx_next = w_last_dig ? '0 : r_scan_idx + SW'(1);
    end

    w_hex_sel = r_ac_hex[4*r_scan_idx +: 4];

    // Only the scanned digit can ever be pulled low, so AN is one-hot-low by
    // construction; the blank window at slot start hides the digit hand-over.
    w_an_next = '1;
    if (w_phase == PH_DRIVE && r_ac_en[r_scan_idx] && w_pwm_on) begin
      w_an_next[r_scan_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_cnt   <= '0;
      r_scan_idx   <= '0;
      r_pwm_cnt    <= '0;
      r_sh_hex     <= '0;
      r_sh_pt      <= '0;
      r_sh_le      <= '0;
      r_sh_en      <= '0;
      r_ac_hex     <= '0;
      r_ac_pt      <= '0;
      r_ac_le      <= '0;
      r_ac_en      <= '0;
      r_hex        <= '0;
      r_p          <= 1'b0;
      r_le         <= 1'b0;
      r_an         <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_slot_cnt   <= w_slot_next;
      r_scan_idx   <= w_idx_next;
      r_pwm_cnt    <= r_pwm_cnt + 4'd1;
      r_frame_done <= w_frame_end;

      // A load on the frame-end edge lands in the shadow while the active
      // buffer takes the previous shadow contents, so that data shows one frame later.
      if (w_frame_end) begin
        r_ac_hex <= r_sh_hex;
        r_ac_pt  <= r_sh_pt;
        r_ac_le  <= r_sh_le;
        r_ac_en  <= r_sh_en;
      end
      if (load) begin
        r_sh_hex <= Hexs;
        r_sh_pt  <= Point;
        r_sh_le  <= Les;
        r_sh_en  <= Dig_en;
      end

      r_hex <= w_hex_sel;
      r_p   <= r_ac_pt[r_scan_idx];
      r_le  <= r_ac_le[r_scan_idx];
      r_an  <= w_an_next;
    end
  end

  assign Hex        = r_hex;
  assign p          = r_p;
  assign LE         = r_le;
  assign AN         = r_an;
  assign scan_idx   = r_scan_idx;
  assign frame_done = r_frame_done;

endmodule
